// File: rtl/mux64_scan_ctrl.sv
// Scan controller for the 64:1 cell mux: steps the select from 0 to a latched
// last index and streams each sampled mux value out as a valid/ready beat.
module mux64_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int SELW  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SELW-1:0]  last_idx,
    output logic [SELW-1:0]  sel,
    input  logic [WIDTH-1:0] mux_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t            state_q;
    logic [SELW-1:0]   sel_q;
    logic [SELW-1:0]   lim_q;
    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    logic [SELW-1:0]   idx_q;
    logic              last_q;
    logic              done_q;
    logic              cap;

    // A new sample may be taken whenever the output slot is empty or being emptied.
    assign cap = (state_q == SCAN) && (!valid_q || out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            lim_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        lim_q   <= last_idx;
                        sel_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        sel_q   <= '0;
                        state_q <= IDLE;
                    end else if (cap) begin
                        data_q  <= mux_y;
                        idx_q   <= sel_q;
                        last_q  <= (sel_q == lim_q);
                        valid_q <= 1'b1;
                        // The select parks on the last index so it can never wrap.
                        if (sel_q == lim_q) begin
                            state_q <= DRAIN;
                        end else begin
                            sel_q <= sel_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        sel_q   <= '0;
                        state_q <= IDLE;
                    end else if (valid_q && out_ready) begin
                        valid_q <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            sel_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
